// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory subsystem (cpu_top, fetch unit, LSU, port arbiter).
// Holds default bus widths, the starvation-counter width and the read-return owner tag.
// No ports; import with cpu_mem_pkg::*.
package cpu_mem_pkg;

  // Default memory geometry: word address and word width.
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  // Width of the fetch starvation counter; limits up to 15 fit.
  localparam int STARVE_CNT_W = 4;

  // Who owns the read data returning from the memory in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive data grants taken while fetch is waiting.
// Ports: clk/reset (sync, active-high), inc_i (data won over a pending fetch),
//        clr_i (fetch served or not requesting), at_limit_o (fetch must win next).
module arb_starve_ctr
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // Clear dominates increment; the count holds once it reaches the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and the LSU;
// data has priority, a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
// Ports: if_* fetch req/gnt/return, d_* data req/gnt/return, mem_* memory port, clk/reset (sync, active-high).
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   at_limit;
  logic   fetch_win;
  logic   data_win;
  owner_t tag_q;
  owner_t tag_d;

  // Fetch wins when alone, or when it has waited through STARVE_LIMIT data grants.
  assign fetch_win = !reset && if_req && (!d_req || at_limit);
  assign data_win  = !reset && d_req && !(if_req && at_limit);

  assign if_gnt = fetch_win;
  assign d_gnt  = data_win;

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (data_win && if_req),
    .clr_i      (fetch_win || !if_req),
    .at_limit_o (at_limit)
  );

  // Memory port drive: idle cycles park address/data at zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_win) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (data_win) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Tag the owner of next cycle's read data; writes produce no return.
  always_comb begin
    tag_d = OWN_NONE;
    if (fetch_win) begin
      tag_d = OWN_IF;
    end else if (data_win && !d_we) begin
      tag_d = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= OWN_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  // The return is also masked by reset itself so a read granted just before
  // reset is dropped in the reset cycle rather than surfacing one cycle late.
  assign if_rvalid = !reset && (tag_q == OWN_IF);
  assign d_rvalid  = !reset && (tag_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with a scoreboard: the driver queues
// expected grant/port values and expected read returns; a negedge monitor checks them.
// Includes a behavioural single-port synchronous memory model.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: write at the edge, read data one cycle after the strobe.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic          rst;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          dreq;
    logic          dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwd;
    logic          eig;
    logic          edg;
    logic          ewe;
    logic [AW-1:0] eaddr;
    int            rport;   // read return expected this cycle: 0 none, 1 fetch, 2 data
    logic [DW-1:0] rdata;
  } vec_t;

  typedef struct {
    int            cyc;
    logic          eig;
    logic          edg;
    logic          ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
  } gexp_t;

  typedef struct {
    int            cyc;
    int            port;
    logic [DW-1:0] data;
  } rexp_t;

  vec_t  vecs[$];
  gexp_t gnt_q[$];
  rexp_t ret_q[$];
  int    cyc;
  int    n_cmp;
  int    n_bad;

  task automatic row(input logic rst, input logic ireq, input logic [AW-1:0] iaddr,
                     input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
                     input logic [DW-1:0] dwd, input logic eig, input logic edg,
                     input logic ewe, input logic [AW-1:0] eaddr, input int rport,
                     input logic [DW-1:0] rdata);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
    v.daddr = daddr; v.dwd = dwd; v.eig = eig; v.edg = edg; v.ewe = ewe;
    v.eaddr = eaddr; v.rport = rport; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  // Monitor: grant/port state every cycle, read returns whenever an rvalid shows.
  initial begin
    gexp_t g;
    rexp_t r;
    logic  ok;
    int    port;
    logic [DW-1:0] data;
    forever begin
      @(negedge clk);
      if (gnt_q.size() > 0) begin
        g = gnt_q.pop_front();
        ok = (if_gnt === g.eig) && (d_gnt === g.edg) && (mem_en === (g.eig | g.edg)) &&
             (mem_we === g.ewe) && (mem_addr === g.eaddr) &&
             (!(g.edg && g.ewe) || (mem_wdata === g.ewd));
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL grant cyc=%0d got ig=%b dg=%b en=%b we=%b addr=%h wd=%h required ig=%b dg=%b we=%b addr=%h wd=%h",
                   g.cyc, if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                   g.eig, g.edg, g.ewe, g.eaddr, g.ewd);
        end
      end
      if (if_rvalid === 1'b1 || d_rvalid === 1'b1) begin
        port = (if_rvalid === 1'b1) ? 1 : 2;
        data = (port == 1) ? if_rdata : d_rdata;
        n_cmp++;
        if (if_rvalid === 1'b1 && d_rvalid === 1'b1) begin
          n_bad++;
          $display("FAIL return cyc=%0d both rvalids high, required at most one", cyc);
        end else if (ret_q.size() == 0) begin
          n_bad++;
          $display("FAIL return cyc=%0d unexpected rvalid on port %0d data=%h, required none", cyc, port, data);
        end else begin
          r = ret_q.pop_front();
          if (r.cyc != cyc || r.port != port || data !== r.data) begin
            n_bad++;
            $display("FAIL return got cyc=%0d port=%0d data=%h required cyc=%0d port=%0d data=%h",
                     cyc, port, data, r.cyc, r.port, r.data);
          end
        end
      end
    end
  end

  // Driver
  initial begin
    gexp_t g;
    rexp_t r;
    n_cmp = 0; n_bad = 0; cyc = -1;
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h5000 + 16'(i);
    mem[8'h10] = 16'hABCD;
    mem[8'h01] = 16'h1111;
    mem[8'h02] = 16'h2222;

    //   rst ireq iaddr dreq we daddr dwd      eig edg ewe eaddr rport rdata
    // reset: requests present but nothing granted
    row(1, 1, 8'h10, 1, 0, 8'h20, 16'h0,    0, 0, 0, 8'h00, 0, 16'h0);    // 0
    row(1, 0, 8'h00, 0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 0, 16'h0);    // 1
    // fetch only
    row(0, 1, 8'h10, 0, 0, 8'h00, 16'h0,    1, 0, 0, 8'h10, 0, 16'h0);    // 2
    row(0, 0, 8'h00, 0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 1, 16'hABCD); // 3
    // data write then read back
    row(0, 0, 8'h00, 1, 1, 8'h20, 16'h1234, 0, 1, 1, 8'h20, 0, 16'h0);    // 4
    row(0, 0, 8'h00, 1, 0, 8'h20, 16'h0,    0, 1, 0, 8'h20, 0, 16'h0);    // 5
    row(0, 0, 8'h00, 0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 2, 16'h1234); // 6
    // alternating back-to-back reads
    row(0, 1, 8'h01, 0, 0, 8'h00, 16'h0,    1, 0, 0, 8'h01, 0, 16'h0);    // 7
    row(0, 0, 8'h00, 1, 0, 8'h02, 16'h0,    0, 1, 0, 8'h02, 1, 16'h1111); // 8
    row(0, 1, 8'h01, 0, 0, 8'h00, 16'h0,    1, 0, 0, 8'h01, 2, 16'h2222); // 9
    row(0, 0, 8'h00, 1, 0, 8'h02, 16'h0,    0, 1, 0, 8'h02, 1, 16'h1111); // 10
    row(0, 0, 8'h00, 0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 2, 16'h2222); // 11
    // starvation: both held 12 cycles -> D,D,D,D,I,D,D,D,D,I,D,D
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 0, 16'h0);    // 12
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 2, 16'h5040); // 13
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 2, 16'h5040); // 14
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 2, 16'h5040); // 15
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    1, 0, 0, 8'h30, 2, 16'h5040); // 16
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 1, 16'h5030); // 17
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 2, 16'h5040); // 18
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 2, 16'h5040); // 19
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 2, 16'h5040); // 20
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    1, 0, 0, 8'h30, 2, 16'h5040); // 21
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 1, 16'h5030); // 22
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 2, 16'h5040); // 23
    row(0, 0, 8'h00, 0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 2, 16'h5040); // 24
    // drive counter to the limit, then reset mid-operation with a read in flight
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 0, 16'h0);    // 25
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 2, 16'h5040); // 26
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 2, 16'h5040); // 27
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 2, 16'h5040); // 28
    row(1, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 0, 0, 8'h00, 0, 16'h0);    // 29 read from 28 dropped
    row(1, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 0, 0, 8'h00, 0, 16'h0);    // 30
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 0, 16'h0);    // 31 counter cleared -> data
    row(0, 1, 8'h30, 1, 0, 8'h40, 16'h0,    0, 1, 0, 8'h40, 2, 16'h5040); // 32
    row(0, 0, 8'h00, 0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 2, 16'h5040); // 33

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset   = vecs[i].rst;
      if_req  = vecs[i].ireq;
      if_addr = vecs[i].iaddr;
      d_req   = vecs[i].dreq;
      d_we    = vecs[i].dwe;
      d_addr  = vecs[i].daddr;
      d_wdata = vecs[i].dwd;
      cyc     = i;
      g.cyc = i; g.eig = vecs[i].eig; g.edg = vecs[i].edg; g.ewe = vecs[i].ewe;
      g.eaddr = vecs[i].eaddr; g.ewd = vecs[i].dwd;
      gnt_q.push_back(g);
      if (vecs[i].rport != 0) begin
        r.cyc = i; r.port = vecs[i].rport; r.data = vecs[i].rdata;
        ret_q.push_back(r);
      end
    end

    @(posedge clk);
    #1;
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    cyc = cyc + 1;
    repeat (3) @(negedge clk);
    #1;

    n_cmp++;
    if (ret_q.size() != 0 || gnt_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d returns and %0d grant checks outstanding, required 0 and 0",
               ret_q.size(), gnt_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port synchronous unified memory between the CPU instruction-fetch unit and the load/store unit inside `cpu_top`. Each cycle it grants at most one requester and drives the memory port. It routes the one-cycle-late read data back to the owner of that access. Data accesses have priority; a starvation counter guarantees fetch progress.

## Interface
- `ADDR_W`, 8, memory word-address width
- `DATA_W`, 16, memory word width
- `STARVE_LIMIT`, 4, maximum consecutive data grants while fetch waits (legal range 1..15)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch read request; held with `if_addr` stable until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted this cycle (combinational)
- `if_rvalid`  out  1  `if_rdata` valid (registered)
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_gnt`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_gnt`  out  1  data access accepted this cycle (combinational)
- `d_rvalid`  out  1  `d_rdata` valid; reads only (registered)
- `d_rdata`  out  DATA_W  load data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after a read strobe

## Operation
- Grant decision, combinational, per cycle:
  - `reset`=1: no grant.
  - Only one request asserted: that requester wins.
  - Both asserted: data wins, unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
- Winner's fields are muxed onto `mem_*` with `mem_en`=1 in the same cycle. Fetch accesses always use `mem_we`=0.
- When there is no grant: `mem_en`=0, `mem_we`=0; `mem_addr`/`mem_wdata` are don't-care and are driven 0.
- `starve_cnt` (4 bits, registered):
  - Increments when data is granted while `if_req`=1.
  - Clears when fetch is granted or `if_req`=0.
  - Never exceeds `STARVE_LIMIT`.
- Read-return tag (registered owner state):
  - States: `OWN_NONE`, `OWN_IF`, `OWN_D`.
  - Next state is `OWN_IF` on a fetch grant, `OWN_D` on a data read grant, and `OWN_NONE` otherwise (idle cycle or data write).
- Return path:
  - Tag `OWN_IF` → `if_rvalid`=1 and `if_rdata`=`mem_rdata`.
  - Tag `OWN_D` → `d_rvalid`=1 and `d_rdata`=`mem_rdata`.
  - Non-owner rvalid is 0. Rdata buses carry `mem_rdata` and are don't-care when rvalid=0.
- Requesters may drop `req` only after `gnt`. Withdrawal before grant is tolerated: the request is simply not served.

## Timing
- Reset:
  - Tag = `OWN_NONE`, `starve_cnt`=0.
  - `if_rvalid`=`d_rvalid`=0 from the first edge with `reset`=1.
  - `if_gnt`=`d_gnt`=`mem_en`=0 while `reset`=1.
- Reset mid-operation: a read granted in the cycle before reset is dropped; no rvalid is produced after reset.
- Throughput and latency:
  - One access per cycle; back-to-back grants are allowed, including alternating owners.
  - Grant in cycle N → rvalid in cycle N+1 for reads.
  - Writes complete at the edge ending cycle N.
- A new grant in cycle N+1 overlaps the cycle-N return; the tag pipeline keeps the two separate.
- Worst-case fetch wait under continuous data traffic: `STARVE_LIMIT` cycles, then grant on the next cycle.
- Simultaneous `d_req` and `if_req` in the first cycle after reset: data granted, `starve_cnt` becomes 1.

## Structure
- Shared package `cpu_mem_pkg`:
  - `ADDR_W` and `DATA_W` defaults.
  - Owner enum `owner_t {OWN_NONE, OWN_IF, OWN_D}`.
  - Used by `cpu_top`, the fetch unit and the LSU.
- One sub-module, `arb_starve_ctr`: saturating counter with `inc`/`clr` inputs and an `at_limit` output, parameterized by `STARVE_LIMIT`.
- Grant mux, `mem_*` drive and tag register are in the top module.

## Test plan
- Fetch only: `if_req`=1, `if_addr`=0x10, memory holds 0xABCD → `if_gnt` in cycle 0; `if_rvalid`=1 and `if_rdata`=0xABCD in cycle 1; `d_rvalid` stays 0.
- Data write then read: write `d_addr`=0x20, `d_wdata`=0x1234, then read 0x20 → `mem_we`=1 on the write cycle and no rvalid for it; the read returns 0x1234 with `d_rvalid` one cycle after its grant.
- Starvation, `STARVE_LIMIT`=4: `if_req` and `d_req` held high for 12 cycles → grant sequence D,D,D,D,I,D,D,D,D,I,D,D.
- Back-to-back alternating reads, addresses 0x01 (I) and 0x02 (D) with distinct contents → each rvalid lands on the correct port with the correct data; a port is never asserted in two consecutive cycles for a single grant.
- Reset mid-operation: data read granted in cycle 5, `reset`=1 in cycle 6 → `d_rvalid`=0 in cycle 6 and later; after reset deassertion `starve_cnt`=0 and the first both-request cycle grants data.
